// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous memory port between fetch and load/store
// Data has priority; fetch is forced through after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  state_t     state_q, state_d;
  owner_t     owner_q, owner_d;
  logic [2:0] lat_q, lat_d;
  logic [3:0] starve_q, starve_d;
  logic       rd_done;

  assign rd_done = (state_q == WAIT) && (lat_q == 3'd1);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_d     = lat_q;
    starve_d  = starve_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        // Gating on rst_n keeps the combinational grant path quiet while reset is held.
        if (rst_n) begin
          if (d_req && !(if_req && starve_q == 4'(STARVE_MAX))) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            if (if_req) starve_d = starve_q + 4'd1;
            if (!d_we) begin
              state_d = WAIT;
              owner_d = OWN_D;
              lat_d   = 3'(MEM_LAT);
            end
          end else if (if_req) begin
            if_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_addr = if_addr;
            starve_d = '0;
            state_d  = WAIT;
            owner_d  = OWN_IF;
            lat_d    = 3'(MEM_LAT);
          end
        end
      end
      WAIT: begin
        lat_d = lat_q - 3'd1;
        if (rd_done) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      lat_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
    end
  end

  // Read data lands in the last WAIT cycle; rvalid follows in the cycle the port is IDLE again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= rd_done && (owner_q == OWN_IF);
      d_rvalid  <= rd_done && (owner_q == OWN_D);
      if (rd_done && owner_q == OWN_IF) if_rdata <= mem_rdata;
      if (rd_done && owner_q == OWN_D)  d_rdata  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int ML   = 2;
  localparam int SM   = 4;
  localparam int NCYC = 1500;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(ML), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
  endtask

  // Model state: port free from cycle free_at; one pending read with due cycle.
  int          free_at, starve, pend_due, next_rst_at;
  bit          pend, pend_d, rst_now, rst_next;
  logic [31:0] exp_ird, exp_drd;
  logic [31:0] hist [NCYC];

  // Requester intent for the next cycle
  bit          f_act, dr_act, f_drop, d_drop;
  logic [AW-1:0] nf_addr, nd_addr;
  logic          nd_we;
  logic [DW-1:0] nd_wdata;

  initial begin
    free_at = 0; starve = 0; pend = 0; pend_d = 0; pend_due = 0;
    exp_ird = '0; exp_drd = '0; rst_now = 0; next_rst_at = 400;
    f_act = 0; dr_act = 0; nf_addr = '0; nd_addr = '0; nd_we = 0; nd_wdata = '0;
    for (cyc = 0; cyc < NCYC; cyc++) begin
      bit wd, wf, chk_bus;
      logic e_en, e_we, e_iv, e_dv;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      int p_f, p_d, p_we, p_wd;

      @(posedge clk);
      #1;
      rst_n   = (cyc >= 3) && !rst_now;
      if_req  = f_act;  if_addr = nf_addr;
      d_req   = dr_act; d_we = nd_we; d_addr = nd_addr; d_wdata = nd_wdata;
      mem_rdata = $urandom;
      hist[cyc] = mem_rdata;
      @(negedge clk);

      wd = 0; wf = 0; chk_bus = 0;
      e_en = 0; e_we = 0; e_iv = 0; e_dv = 0; e_addr = '0; e_wd = '0;
      if (!rst_n) begin
        pend = 0; starve = 0; free_at = 0; exp_ird = '0; exp_drd = '0; chk_bus = 1;
      end else begin
        if (pend && pend_due == cyc) begin
          if (pend_d) begin e_dv = 1; exp_drd = hist[cyc-1]; end
          else        begin e_iv = 1; exp_ird = hist[cyc-1]; end
          pend = 0;
        end
        if (cyc < free_at) chk_bus = 1;
        else begin
          wd = d_req && !(if_req && starve == SM);
          wf = if_req && !wd;
          if (wd) begin
            e_en = 1; e_we = d_we; e_addr = d_addr; e_wd = d_wdata; chk_bus = 1;
            if (if_req && starve < SM) starve++;
            if (!d_we) begin pend = 1; pend_d = 1; pend_due = cyc + ML + 1; free_at = pend_due; end
          end else if (wf) begin
            e_en = 1; e_addr = if_addr; chk_bus = 1; starve = 0;
            pend = 1; pend_d = 0; pend_due = cyc + ML + 1; free_at = pend_due;
          end
        end
      end

      check("if_gnt", 32'(if_gnt), 32'(wf));
      check("d_gnt", 32'(d_gnt), 32'(wd));
      check("mem_en", 32'(mem_en), 32'(e_en));
      check("if_rvalid", 32'(if_rvalid), 32'(e_iv));
      check("d_rvalid", 32'(d_rvalid), 32'(e_dv));
      check("if_rdata", if_rdata, exp_ird);
      check("d_rdata", d_rdata, exp_drd);
      if (chk_bus) begin
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_wdata", mem_wdata, e_wd);
      end

      // Pull reset one cycle into a data read to abort it.
      rst_next = 0;
      if (cyc >= next_rst_at && wd && !d_we) begin rst_next = 1; next_rst_at += 600; end
      rst_now = rst_next;

      if (cyc < 500)      begin p_f = 50;  p_d = 50;  p_we = 50;  p_wd = 10; end
      else if (cyc < 700) begin p_f = 100; p_d = 100; p_we = 100; p_wd = 0;  end
      else                begin p_f = 60;  p_d = 60;  p_we = 30;  p_wd = 10; end

      f_drop = 0; d_drop = 0;
      if (f_act && wf) f_act = 0;
      else if (f_act && $urandom_range(99) < p_wd) begin f_act = 0; f_drop = 1; end
      if (!f_act && !f_drop && $urandom_range(99) < p_f) begin
        f_act = 1; nf_addr = AW'($urandom);
      end
      if (dr_act && wd) dr_act = 0;
      else if (dr_act && $urandom_range(99) < p_wd) begin dr_act = 0; d_drop = 1; end
      if (!dr_act && !d_drop && $urandom_range(99) < p_d) begin
        dr_act = 1; nd_we = ($urandom_range(99) < p_we); nd_addr = AW'($urandom); nd_wdata = $urandom;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
